// File: rtl/axis_slave_fifo.sv
// AXI4-Stream sink buffering beats in a DEPTH-entry first-word-fall-through FIFO.
// Reports fill level, almost-full and the number of complete packets currently held.
module axis_slave_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                       ACLK,
    input  logic                       ARSTN,
    input  logic                       S_TVALID,
    input  logic [DATA_WIDTH-1:0]      S_TDATA,
    input  logic                       S_TLAST,
    output logic                       S_TREADY,
    output logic                       M_TVALID,
    output logic [DATA_WIDTH-1:0]      M_TDATA,
    output logic                       M_TLAST,
    input  logic                       M_TREADY,
    output logic [$clog2(DEPTH):0]     FILL_LEVEL,
    output logic                       ALMOST_FULL,
    output logic [$clog2(DEPTH):0]     PKT_COUNT
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_WIDTH + 1;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axis_slave_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("axis_slave_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          ready_en_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic          s_ready;
    logic          m_valid;
    logic          push;
    logic          pop;
    logic          pkt_in;
    logic          pkt_out;

    // Ready depends only on registered state; a pop while full frees the slot next cycle.
    assign s_ready = ready_en_q && (count_q != FULL_CNT);
    assign m_valid = (count_q != '0);
    assign push    = S_TVALID && s_ready;
    assign pop     = m_valid && M_TREADY;
    assign head    = mem_q[rd_ptr_q];
    assign pkt_in  = push && S_TLAST;
    assign pkt_out = pop && head[DATA_WIDTH];

    assign S_TREADY    = s_ready;
    assign M_TVALID    = m_valid;
    assign M_TDATA     = m_valid ? head[DATA_WIDTH-1:0] : '0;
    assign M_TLAST     = m_valid && head[DATA_WIDTH];
    assign FILL_LEVEL  = count_q;
    assign ALMOST_FULL = (count_q >= AFULL_CNT);
    assign PKT_COUNT   = pkt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pkt_d    = pkt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        case ({pkt_in, pkt_out})
            2'b10:   pkt_d = pkt_q + (AW+1)'(1);
            2'b01:   pkt_d = pkt_q - (AW+1)'(1);
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_q      <= pkt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; M_* are gated while empty.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {S_TLAST, S_TDATA};
        end
    end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Bench for axis_slave_fifo: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_axis_slave_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic          ACLK = 1'b0;
    logic          ARSTN;
    logic          S_TVALID;
    logic [DW-1:0] S_TDATA;
    logic          S_TLAST;
    logic          S_TREADY;
    logic          M_TVALID;
    logic [DW-1:0] M_TDATA;
    logic          M_TLAST;
    logic          M_TREADY;
    logic [3:0]    FILL_LEVEL;
    logic          ALMOST_FULL;
    logic [3:0]    PKT_COUNT;

    axis_slave_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .ACLK(ACLK), .ARSTN(ARSTN),
        .S_TVALID(S_TVALID), .S_TDATA(S_TDATA), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
        .M_TVALID(M_TVALID), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
        .FILL_LEVEL(FILL_LEVEL), .ALMOST_FULL(ALMOST_FULL), .PKT_COUNT(PKT_COUNT)
    );

    always #5 ACLK = ~ACLK;

    typedef logic [DW:0] beat_t;
    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          r;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_last;
        int          e_fill;
        int          e_pkt;
        bit          e_afull;
        bit          e_srdy;
    } vec_t;

    beat_t q[$];
    beat_t dut_log[$];
    bit    m_rdy;
    int    n_checks = 0;
    int    n_err    = 0;
    vec_t  tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][DW]) n++;
        return n;
    endfunction

    task automatic check_model();
        beat_t h;
        int    sz;
        sz = q.size();
        h  = (sz != 0) ? q[0] : '0;
        check("m_tvalid",    64'(M_TVALID),    64'(sz != 0));
        check("m_tdata",     64'(M_TDATA),     64'(h[DW-1:0]));
        check("m_tlast",     64'(M_TLAST),     64'(h[DW]));
        check("fill_level",  64'(FILL_LEVEL),  64'(sz));
        check("almost_full", 64'(ALMOST_FULL), 64'(sz >= AFULL));
        check("pkt_count",   64'(PKT_COUNT),   64'(model_pkts()));
        check("s_tready",    64'(S_TREADY),    64'(m_rdy && (sz < DEPTH)));
    endtask

    // Drive one cycle, advance the model across the edge, sample 1ns after it.
    task automatic clk_step(input bit v, input logic [31:0] d, input bit l, input bit r);
        bit m_push, m_pop;
        S_TVALID = v;
        S_TDATA  = d;
        S_TLAST  = l;
        M_TREADY = r;
        #1;
        m_push = v && m_rdy && (q.size() < DEPTH);
        m_pop  = r && (q.size() != 0);
        if (M_TVALID && M_TREADY) dut_log.push_back({M_TLAST, M_TDATA});
        @(posedge ACLK);
        #1;
        if (!ARSTN) begin
            q.delete();
            m_rdy = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back({l, d});
            m_rdy = 1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            clk_step(0, 0, 0, 1);
            check_model();
            n++;
        end
        check(name, 64'(FILL_LEVEL), 64'(0));
    endtask

    function automatic vec_t mk(bit v, logic [31:0] d, bit l, bit r, bit ev, logic [31:0] ed,
                                bit el, int ef, int ep, bit ea, bit es);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.r = r;
        t.e_valid = ev; t.e_data = ed; t.e_last = el; t.e_fill = ef;
        t.e_pkt = ep; t.e_afull = ea; t.e_srdy = es;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev_data;
        bit          prev_stall;
        bit          tr_seq [6];
        ARSTN = 0; S_TVALID = 0; S_TDATA = '0; S_TLAST = 0; M_TREADY = 0;
        m_rdy = 0;

        tbl.push_back(mk(1, 32'hDEADBEEF, 1, 0, 1, 32'hDEADBEEF, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 0, 0, 1));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1, 32'(k), 0, 0, 1, 32'h1, 0, k, 0, k >= 6, k < 8));
        tbl.push_back(mk(1, 32'h9, 0, 0, 1, 32'h1, 0, 8, 0, 1, 0));
        tbl.push_back(mk(1, 32'h9, 0, 1, 1, 32'h2, 0, 7, 0, 1, 1));
        tbl.push_back(mk(1, 32'h9, 0, 0, 1, 32'h2, 0, 8, 0, 1, 0));

        // Reset held for three edges, then released between edges.
        for (int i = 0; i < 3; i++) begin
            clk_step(0, 0, 0, 0);
            check_model();
        end
        ARSTN = 1;
        #1;
        check("s_tready_before_first_edge", 64'(S_TREADY), 64'(0));
        clk_step(0, 0, 0, 0);
        check_model();

        foreach (tbl[i]) begin
            clk_step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            check($sformatf("vec%0d_m_tvalid", i), 64'(M_TVALID),    64'(tbl[i].e_valid));
            check($sformatf("vec%0d_m_tdata", i),  64'(M_TDATA),     64'(tbl[i].e_data));
            check($sformatf("vec%0d_m_tlast", i),  64'(M_TLAST),     64'(tbl[i].e_last));
            check($sformatf("vec%0d_fill", i),     64'(FILL_LEVEL),  64'(tbl[i].e_fill));
            check($sformatf("vec%0d_pkt", i),      64'(PKT_COUNT),   64'(tbl[i].e_pkt));
            check($sformatf("vec%0d_afull", i),    64'(ALMOST_FULL), 64'(tbl[i].e_afull));
            check($sformatf("vec%0d_s_tready", i), 64'(S_TREADY),    64'(tbl[i].e_srdy));
        end
        drain("drain_after_full");

        // Streaming through pointer wrap at one beat per cycle.
        dut_log.delete();
        for (int i = 0; i < 20; i++) begin
            clk_step(1, 32'h100 + 32'(i), 0, 1);
            check_model();
            check("stream_head", 64'(M_TDATA), 64'(32'h100 + 32'(i)));
            if (i >= 1) check("stream_fill", 64'(FILL_LEVEL), 64'(1));
        end
        check("stream_count", 64'(dut_log.size()), 64'(19));
        foreach (dut_log[i])
            check("stream_order", 64'(dut_log[i]), 64'({1'b0, 32'h100 + 32'(i)}));
        drain("drain_after_stream");

        // Backpressure on a three-beat packet.
        dut_log.delete();
        clk_step(1, 32'hA, 0, 0);
        clk_step(1, 32'hB, 0, 0);
        clk_step(1, 32'hC, 1, 0);
        check("bp_pkt_one", 64'(PKT_COUNT), 64'(1));
        tr_seq = '{1, 0, 0, 1, 0, 1};
        clk_step(0, 0, 0, 0);
        foreach (tr_seq[i]) begin
            prev_data  = M_TDATA;
            prev_stall = M_TVALID && !tr_seq[i];
            clk_step(0, 0, 0, tr_seq[i]);
            check_model();
            if (prev_stall) check("bp_hold", 64'(M_TDATA), 64'(prev_data));
        end
        check("bp_pkt_zero", 64'(PKT_COUNT), 64'(0));
        check("bp_out_count", 64'(dut_log.size()), 64'(3));
        if (dut_log.size() == 3) begin
            check("bp_out0", 64'(dut_log[0]), 64'({1'b0, 32'hA}));
            check("bp_out1", 64'(dut_log[1]), 64'({1'b0, 32'hB}));
            check("bp_out2", 64'(dut_log[2]), 64'({1'b1, 32'hC}));
        end

        // Asynchronous reset in the middle of buffered traffic.
        for (int i = 0; i < 5; i++) clk_step(1, 32'h50 + 32'(i), i == 2, 0);
        check("mid_fill", 64'(FILL_LEVEL), 64'(5));
        check("mid_pkt",  64'(PKT_COUNT),  64'(1));
        #3;
        ARSTN = 0;
        #1;
        check("arst_m_tvalid", 64'(M_TVALID),    64'(0));
        check("arst_m_tdata",  64'(M_TDATA),     64'(0));
        check("arst_fill",     64'(FILL_LEVEL),  64'(0));
        check("arst_pkt",      64'(PKT_COUNT),   64'(0));
        check("arst_s_tready", 64'(S_TREADY),    64'(0));
        check("arst_afull",    64'(ALMOST_FULL), 64'(0));
        q.delete();
        m_rdy = 0;
        clk_step(0, 0, 0, 0);
        clk_step(0, 0, 0, 0);
        ARSTN = 1;
        clk_step(0, 0, 0, 0);
        check_model();

        // Randomized traffic with varying backpressure.
        for (int i = 0; i < 400; i++) begin
            int p_ready;
            p_ready = (i < 200) ? 30 : 80;
            clk_step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 99) < p_ready);
            check_model();
        end
        drain("drain_after_random");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
